// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side signal bundle for dmem_arbiter.
// slave = arbiter side, master = requesters plus memory (testbench side).
interface dmem_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 128
);
  localparam int AW = $clog2(DEPTH);

  logic              r0_req;
  logic              r0_we;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_wdata;
  logic              r0_gnt;
  logic              r0_done;
  logic              r0_err;
  logic [DATA_W-1:0] r0_rdata;

  logic              r1_req;
  logic              r1_we;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_wdata;
  logic              r1_gnt;
  logic              r1_done;
  logic              r1_err;
  logic [DATA_W-1:0] r1_rdata;

  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata,
    output r0_gnt, r0_done, r0_err, r0_rdata,
    input  r1_req, r1_we, r1_addr, r1_wdata,
    output r1_gnt, r1_done, r1_err, r1_rdata,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata,
    input  r0_gnt, r0_done, r0_err, r0_rdata,
    output r1_req, r1_we, r1_addr, r1_wdata,
    input  r1_gnt, r1_done, r1_err, r1_rdata,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer for the 128-word data memory.
// One access per IDLE->ACCESS->RESP pass; bad addresses are rejected, never aliased.
module dmem_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 128
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [ADDR_W-3:0] DEPTH_W = (ADDR_W-2)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_nx;

  logic              grant0, grant1;
  logic              win_we, win_ok;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  logic              sel, rr_last, l_we, l_ok;
  logic              gnt0, gnt1, done0, done1, err0, err1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              mem_we_r;
  logic [AW-1:0]     mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Grants are only decided in IDLE; on a tie the port that did not win last time goes.
  always_comb begin
    state_nx = state;
    grant0   = 1'b0;
    grant1   = 1'b0;
    case (state)
      IDLE: begin
        grant0 = bus.r0_req & (~bus.r1_req | rr_last);
        grant1 = bus.r1_req & ~grant0;
        if (grant0 | grant1) state_nx = ACCESS;
      end
      ACCESS:  state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    win_we    = grant1 ? bus.r1_we    : bus.r0_we;
    win_addr  = grant1 ? bus.r1_addr  : bus.r0_addr;
    win_wdata = grant1 ? bus.r1_wdata : bus.r0_wdata;
    win_ok    = (win_addr[1:0] == 2'b00) && (win_addr[ADDR_W-1:2] < DEPTH_W);
  end

  // Memory controls are registered at the grant edge so mem_we is a clean single-cycle pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel         <= 1'b0;
      rr_last     <= 1'b1;
      l_we        <= 1'b0;
      l_ok        <= 1'b0;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      err0        <= 1'b0;
      err1        <= 1'b0;
      rdata0      <= '0;
      rdata1      <= '0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
    end else begin
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      mem_we_r <= 1'b0;
      if (grant0 | grant1) begin
        sel         <= grant1;
        rr_last     <= grant1;
        l_we        <= win_we;
        l_ok        <= win_ok;
        gnt0        <= grant0;
        gnt1        <= grant1;
        mem_we_r    <= win_we & win_ok;
        mem_addr_r  <= win_addr[AW+1:2];
        mem_wdata_r <= win_wdata;
      end
      if (state == RESP) begin
        if (!sel) begin
          done0 <= 1'b1;
          err0  <= ~l_ok;
          if (l_ok && !l_we) rdata0 <= bus.mem_rdata;
        end else begin
          done1 <= 1'b1;
          err1  <= ~l_ok;
          if (l_ok && !l_we) rdata1 <= bus.mem_rdata;
        end
      end
    end
  end

  assign bus.r0_gnt    = gnt0;
  assign bus.r0_done   = done0;
  assign bus.r0_err    = err0;
  assign bus.r0_rdata  = rdata0;
  assign bus.r1_gnt    = gnt1;
  assign bus.r1_done   = done1;
  assign bus.r1_err    = err1;
  assign bus.r1_rdata  = rdata1;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized self-checking bench for dmem_arbiter against a transaction-level model
// (round-robin winner, word memory image, per-port returned data).
module tb_dmem_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 128;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

  dmem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic [31:0] mem [DEPTH] = '{default: '0};
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
  assign bus.mem_rdata = mem[bus.mem_addr];

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] m_rdata [2];
  int          last;
  logic        pw [2];
  logic [31:0] pa [2];
  logic [31:0] pd [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
    pw[p] = we;
    pa[p] = a;
    pd[p] = d;
  endtask

  task automatic drive(input int p, input logic req);
    if (p == 0) begin
      bus.r0_req = req; bus.r0_we = pw[0]; bus.r0_addr = pa[0]; bus.r0_wdata = pd[0];
    end else begin
      bus.r1_req = req; bus.r1_we = pw[1]; bus.r1_addr = pa[1]; bus.r1_wdata = pd[1];
    end
  endtask

  function automatic logic gnt_of(input int p);
    return (p == 0) ? bus.r0_gnt : bus.r1_gnt;
  endfunction
  function automatic logic done_of(input int p);
    return (p == 0) ? bus.r0_done : bus.r1_done;
  endfunction
  function automatic logic err_of(input int p);
    return (p == 0) ? bus.r0_err : bus.r1_err;
  endfunction
  function automatic logic [31:0] rdata_of(input int p);
    return (p == 0) ? bus.r0_rdata : bus.r1_rdata;
  endfunction

  // One access by port p whose request is already applied while the arbiter is idle.
  task automatic run(input int p);
    logic        ok;
    int unsigned idx;
    idx = pa[p] / 4;
    ok  = (pa[p] % 4 == 0) && (idx < DEPTH);
    tick();
    check("gnt", 32'(gnt_of(p)), 32'd1);
    check("gnt_other", 32'(gnt_of(1 - p)), 32'd0);
    check("mem_we_access", 32'(bus.mem_we), 32'(pw[p] && ok));
    check("busy_access", 32'(bus.busy), 32'd1);
    if (ok) check("mem_addr", 32'(bus.mem_addr), idx);
    if (ok && pw[p]) check("mem_wdata", bus.mem_wdata, pd[p]);
    drive(p, 1'b0);
    if (ok && pw[p]) ref_mem[idx] = pd[p];
    tick();
    check("resp_quiet", {28'd0, bus.r1_gnt, bus.r0_gnt, bus.r1_done, bus.r0_done}, 32'd0);
    check("mem_we_resp", 32'(bus.mem_we), 32'd0);
    tick();
    check("done", 32'(done_of(p)), 32'd1);
    check("done_other", 32'(done_of(1 - p)), 32'd0);
    check("err", 32'(err_of(p)), 32'(!ok));
    if (ok && !pw[p]) m_rdata[p] = ref_mem[idx];
    check("rdata", rdata_of(p), m_rdata[p]);
    check("rdata_other", rdata_of(1 - p), m_rdata[1 - p]);
    check("busy_idle", 32'(bus.busy), 32'd0);
    last = p;
  endtask

  // mask bit0 = port 0 requests, bit1 = port 1 requests.
  task automatic serve(input logic [1:0] mask);
    int w;
    if (mask == 2'b11) begin
      w = 1 - last;
      drive(0, 1'b1);
      drive(1, 1'b1);
      run(w);
      run(1 - w);
    end else begin
      w = mask[1] ? 1 : 0;
      drive(w, 1'b1);
      run(w);
    end
  endtask

  task automatic rand_op(input int p);
    int unsigned k;
    logic [31:0] a;
    k = $urandom_range(0, 9);
    if (k <= 6)      a = 32'($urandom_range(0, 15) * 4);
    else if (k == 7) a = 32'($urandom_range(0, 127) * 4 + $urandom_range(1, 3));
    else if (k == 8) a = $urandom | 32'h200;
    else             a = 32'h1FC;
    set_op(p, 1'($urandom_range(0, 1)), a, $urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    m_rdata[0] = '0;
    m_rdata[1] = '0;
    last = 1;
    set_op(0, 1'b0, '0, '0);
    set_op(1, 1'b0, '0, '0);
    drive(0, 1'b0);
    drive(1, 1'b0);
    reset = 1'b1;
    tick();
    tick();
    check("rst_ctrl", {26'd0, bus.r0_gnt, bus.r1_gnt, bus.r0_done, bus.r1_done, bus.mem_we, bus.busy}, 32'd0);
    check("rst_err", {30'd0, bus.r0_err, bus.r1_err}, 32'd0);
    check("rst_rdata0", bus.r0_rdata, 32'd0);
    check("rst_rdata1", bus.r1_rdata, 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    set_op(0, 1'b1, 32'h10, 32'hDEADBEEF); serve(2'b01);
    set_op(0, 1'b0, 32'h10, 32'h0);        serve(2'b01);
    check("read_10", bus.r0_rdata, 32'hDEADBEEF);
    set_op(0, 1'b1, 32'h1FC, 32'h12345678); serve(2'b01);
    set_op(0, 1'b0, 32'h1FC, 32'h0);        serve(2'b01);
    check("read_1fc", bus.r0_rdata, 32'h12345678);

    set_op(1, 1'b1, 32'h202, 32'hBAD0BAD0); serve(2'b10);
    set_op(1, 1'b1, 32'h200, 32'hBAD1BAD1); serve(2'b10);
    check("mem0_kept", mem[0], 32'd0);

    set_op(0, 1'b0, 32'h10, 32'h0);
    set_op(1, 1'b0, 32'h1FC, 32'h0);
    serve(2'b11);
    serve(2'b11);

    // Port 0 pulses its request only while port 1 is being served.
    set_op(1, 1'b0, 32'h10, 32'h0);
    drive(1, 1'b1);
    tick();
    check("pulse_gnt1", 32'(bus.r1_gnt), 32'd1);
    drive(1, 1'b0);
    set_op(0, 1'b0, 32'h14, 32'h0);
    drive(0, 1'b1);
    tick();
    drive(0, 1'b0);
    check("pulse_resp_gnt0", 32'(bus.r0_gnt), 32'd0);
    tick();
    check("pulse_done1", 32'(bus.r1_done), 32'd1);
    m_rdata[1] = ref_mem[4];
    check("pulse_rdata1", bus.r1_rdata, m_rdata[1]);
    last = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("pulse_r0_idle", {30'd0, bus.r0_gnt, bus.r0_done}, 32'd0);
    end

    for (int n = 0; n < 60; n++) begin
      logic [1:0] mask;
      mask = 2'($urandom_range(1, 3));
      if (mask[0]) rand_op(0);
      if (mask[1]) rand_op(1);
      serve(mask);
    end

    // Reset in the middle of a legal write: nothing commits, no done, round-robin restarts.
    set_op(0, 1'b1, 32'h20, 32'hCAFEF00D);
    drive(0, 1'b1);
    tick();
    check("rstmid_we_before", 32'(bus.mem_we), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("rstmid_we", 32'(bus.mem_we), 32'd0);
    check("rstmid_busy", 32'(bus.busy), 32'd0);
    drive(0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    last = 1;
    m_rdata[0] = '0;
    m_rdata[1] = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rstmid_no_done", {30'd0, bus.r0_done, bus.r1_done}, 32'd0);
    end
    check("rstmid_mem", mem[8], ref_mem[8]);
    set_op(0, 1'b0, 32'h20, 32'h0);
    set_op(1, 1'b0, 32'h10, 32'h0);
    serve(2'b11);

    begin
      int nbad;
      nbad = 0;
      for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) nbad++;
      check("mem_image", 32'(nbad), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
